// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle.
//   redirect_valid/redirect_pc : PC override from the branch/jump logic
//   mem_req/mem_addr           : instruction memory read request (always accepted)
//   mem_rvalid/mem_rdata       : instruction memory read response
//   instr_valid/instr/instr_pc : fetched instruction presented to decode
//   instr_ready                : decode accepts the presented instruction
// modport master : the fetch unit
// modport slave  : memory + decode + redirect source
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_rvalid, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_rvalid, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues one outstanding read at a
// time, and presents each returned word to decode with valid/ready.
// A redirect overrides sequential PC+PC_STEP fetch; a response that was
// in flight when a redirect arrived is dropped.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : instr_fetch_unit_if.master (redirect, memory and decode signals)
module instr_fetch_unit #(
  parameter int               ADDR_W   = 16,
  parameter int               INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int               PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               discard_q, discard_d;
  logic               instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

  // Gated with rst_n so no request is visible while reset is held.
  assign bus.mem_req     = rst_n && (state_q == S_REQ) && !bus.redirect_valid;
  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    case (state_q)
      S_REQ: begin
        // mem_rvalid here is a protocol violation and is ignored.
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        else                    state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_rvalid && bus.redirect_valid) begin
          // Response consumed by the redirect; nothing left in flight.
          pc_d      = bus.redirect_pc;
          discard_d = 1'b0;
          state_d   = S_REQ;
        end else if (bus.mem_rvalid && discard_q) begin
          discard_d = 1'b0;
          state_d   = S_REQ;
        end else if (bus.mem_rvalid) begin
          instr_d       = bus.mem_rdata;
          instr_pc_d    = pc_q;
          pc_d          = pc_q + ADDR_W'(PC_STEP);
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end else if (bus.redirect_valid) begin
          // Old response still owed by memory: remember to drop it.
          pc_d      = bus.redirect_pc;
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect flushes the held word even if decode is ready.
        if (bus.redirect_valid) begin
          instr_valid_d = 1'b0;
          pc_d          = bus.redirect_pc;
          state_d       = S_REQ;
        end else if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int          AW       = 16;
  localparam int          IW       = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          PC_STEP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus();

  instr_fetch_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: program-order view of fetch.
  logic [15:0] exp_pc;   // address of the next instruction decode should see
  logic        pend;     // memory owes one response
  int          cnt;      // cycles left before that response
  logic [15:0] paddr;    // address of the owed response
  int          lat;      // current memory latency
  int          cyc, last_acc, n_acc, idle;
  logic        tp_on;

  function automatic logic [15:0] dat(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: memory responds, inputs driven, outputs checked, model advanced.
  task automatic step(input logic redir, input logic [15:0] rpc, input logic rdy);
    logic rv;
    @(negedge clk);
    rv = 1'b0;
    if (pend) begin
      if (cnt == 0) begin rv = 1'b1; pend = 1'b0; end
      else cnt--;
    end
    bus.mem_rvalid     = rv;
    bus.mem_rdata      = rv ? dat(paddr) : 16'h0000;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = rdy;
    #1;
    cyc++;
    if (redir)           chk("req_during_redirect", 32'(bus.mem_req), 32'(0));
    if (bus.instr_valid) chk("req_while_holding", 32'(bus.mem_req), 32'(0));
    if (bus.mem_req) begin
      chk("single_outstanding", 32'(pend | rv), 32'(0));
      chk("mem_addr", 32'(bus.mem_addr), 32'(exp_pc));
      pend = 1'b1; cnt = lat - 1; paddr = bus.mem_addr;
    end
    if (bus.instr_valid) begin
      chk("instr_pc", 32'(bus.instr_pc), 32'(exp_pc));
      chk("instr", 32'(bus.instr), 32'(dat(exp_pc)));
    end
    if (bus.instr_valid && rdy && !redir) begin
      if (tp_on && n_acc > 0) chk("throughput", 32'(cyc - last_acc), 32'(3));
      last_acc = cyc; n_acc++;
      exp_pc = exp_pc + 16'(PC_STEP);
    end
    if (redir) exp_pc = rpc;
    if (bus.mem_req || bus.instr_valid || pend) idle = 0; else idle++;
    if (idle > 8) begin chk("fetch_stalled", 32'(idle), 32'(0)); idle = 0; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'(0));
    chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'(0));
    chk({tag, "_instr"}, 32'(bus.instr), 32'(0));
    chk({tag, "_instr_pc"}, 32'(bus.instr_pc), 32'(0));
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(RESET_PC));
  endtask

  initial begin
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
    exp_pc = RESET_PC; pend = 1'b0; cnt = 0; paddr = '0; lat = 1;
    cyc = 0; last_acc = 0; n_acc = 0; idle = 0; tp_on = 1'b0;

    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // Sequential fetch, latency 1, decode always ready: 0,4,8 at one per 3 cycles.
    tp_on = 1'b1;
    repeat (9) step(1'b0, 16'h0, 1'b1);
    chk("seq_accepts", 32'(n_acc), 32'(3));
    tp_on = 1'b0;

    // Backpressure: hold several cycles, then release.
    repeat (8) step(1'b0, 16'h0, 1'b0);
    chk("bp_holding", 32'(bus.instr_valid), 32'(1));
    repeat (6) step(1'b0, 16'h0, 1'b1);

    // Redirect while waiting on a latency-3 response.
    lat = 3;
    for (int k = 0; k < 10 && !pend; k++) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h0100, 1'b1);
    repeat (12) step(1'b0, 16'h0, 1'b1);

    // Redirect in the same cycle the response returns.
    lat = 2;
    for (int k = 0; k < 10 && !(pend && cnt == 0); k++) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h0200, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    chk("redir_rvalid_req", 32'(bus.mem_req), 32'(1));
    chk("redir_rvalid_addr", 32'(bus.mem_addr), 32'(16'h0200));
    repeat (6) step(1'b0, 16'h0, 1'b1);

    // Redirect in HOLD with decode ready: held word is flushed.
    lat = 1;
    for (int k = 0; k < 10 && !bus.instr_valid; k++) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0300, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    chk("hold_flush_addr", 32'(bus.mem_addr), 32'(16'h0300));
    repeat (4) step(1'b0, 16'h0, 1'b1);

    // Wrap: FFFC then 0000.
    for (int k = 0; k < 10 && !bus.instr_valid; k++) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'hFFFC, 1'b1);
    repeat (4) step(1'b0, 16'h0, 1'b1);
    chk("wrap_addr", 32'(bus.mem_addr), 32'(16'h0000));
    repeat (4) step(1'b0, 16'h0, 1'b1);

    // Randomized traffic: latency, backpressure and redirects.
    for (int i = 0; i < 400; i++) begin
      if (!pend) lat = $urandom_range(1, 4);
      step($urandom_range(0, 9) == 0, 16'($urandom_range(0, 65535)),
           $urandom_range(0, 9) < 7);
    end
    for (int k = 0; k < 12; k++) step(1'b0, 16'h0, 1'b1);

    // Reset in the middle of WAIT, then a stale response after release.
    lat = 3;
    for (int k = 0; k < 10 && !(bus.instr_valid == 1'b0 && pend); k++) step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    rst_n = 1'b0;
    bus.mem_rvalid = 1'b0; bus.redirect_valid = 1'b0;
    pend = 1'b0; exp_pc = RESET_PC;
    #1 chk_reset_outputs("midwait_reset");
    @(negedge clk); #1 chk("rst_held_mem_req", 32'(bus.mem_req), 32'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hDEAD; bus.instr_ready = 1'b1;
    #1;
    chk("rst_restart_req", 32'(bus.mem_req), 32'(1));
    chk("rst_restart_addr", 32'(bus.mem_addr), 32'(RESET_PC));
    if (bus.mem_req) begin pend = 1'b1; cnt = lat - 1; paddr = bus.mem_addr; end
    n_acc = 0;
    repeat (10) step(1'b0, 16'h0, 1'b1);
    chk("rst_restart_accepts", 32'(n_acc), 32'(2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $error("FAIL timeout observed=running expected=finished");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end
endmodule
